muldiv_unit: RTL and testbench

Multi-cycle integer multiply/divide unit for the execute stage, implementing the RV32M/RV64M operation set at a parametrised data width. The execute stage starts it when it decodes an M-extension instruction. The unit holds the pipeline with a stall request while it iterates, then presents a one-cycle result for writeback. It extends single-cycle ALU execution with a sequential shift-add/restoring-divide datapath, sign handling, special-case fast paths and flush support.

---
 rtl/muldiv_unit.sv | 163 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Sequential RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide,
// sign fix-up and divide-by-zero/overflow fast paths, with flush and stall support.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o,
  output logic [1:0]      dbg_state_o
);

  // Handshake: a request is taken on any edge where state is IDLE, start_i=1 and
  // flush_i=0; stall_o holds the pipeline until the one-cycle done_o strobe, during
  // which result_o/rd_addr_o are valid and the pipeline advances.

  localparam int PW = 2 * XLEN;
  localparam int AW = PW + 1;
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE = 2'd0, PREP = 2'd1, CALC = 2'd2, DONE = 2'd3} state_t;
  state_t state, state_nxt;

  logic [2:0]      f3_q;
  logic [XLEN-1:0] op1_q, op2_q;
  logic [4:0]      rd_q;
  logic [PW-1:0]   a_q;
  logic [XLEN-1:0] b_q;
  logic [AW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic            neg_q, rneg_q, fast_q;

  // Operand decode, evaluated in PREP from the latched request.
  logic            is_div, s1, s2, neg1, neg2, div_zero, div_ovf;
  logic [XLEN-1:0] mag1, mag2, fixed_res;

  assign is_div    = f3_q[2];
  assign s1        = is_div ? ~f3_q[0] : (f3_q != 3'b011);
  assign s2        = is_div ? ~f3_q[0] : ~f3_q[1];
  assign neg1      = s1 & op1_q[XLEN-1];
  assign neg2      = s2 & op2_q[XLEN-1];
  assign mag1      = neg1 ? (~op1_q + XLEN'(1)) : op1_q;
  assign mag2      = neg2 ? (~op2_q + XLEN'(1)) : op2_q;
  assign div_zero  = is_div & (op2_q == '0);
  assign div_ovf   = is_div & ~f3_q[0] & (op1_q == {1'b1, {(XLEN-1){1'b0}}}) & (op2_q == '1);
  assign fixed_res = div_zero ? (f3_q[1] ? op1_q : '1) : (f3_q[1] ? '0 : op1_q);

  // One iteration: multiply adds the shifted multiplicand, divide does a trial subtract
  // of the divisor from the remainder with the next dividend bit shifted in.
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] trial;
  logic [AW-1:0]   mul_acc, div_acc, step_acc;

  assign rem_sh   = {acc[PW-1:XLEN], a_q[XLEN-1]};
  assign trial    = {1'b0, rem_sh} - {2'b00, b_q};
  assign mul_acc  = acc + (b_q[0] ? {1'b0, a_q} : '0);
  assign div_acc  = trial[XLEN+1] ? {rem_sh, acc[XLEN-2:0], 1'b0}
                                  : {trial[XLEN:0], acc[XLEN-2:0], 1'b1};
  assign step_acc = is_div ? div_acc : mul_acc;

  logic [PW-1:0]   prod_mag, prod;
  logic [XLEN-1:0] quot, rem, q_fix, r_fix, calc_res, final_res;

  assign prod_mag  = step_acc[PW-1:0];
  assign prod      = neg_q ? (~prod_mag + PW'(1)) : prod_mag;
  assign quot      = step_acc[XLEN-1:0];
  assign rem       = step_acc[PW-1:XLEN];
  assign q_fix     = neg_q ? (~quot + XLEN'(1)) : quot;
  assign r_fix     = rneg_q ? (~rem + XLEN'(1)) : rem;
  assign calc_res  = is_div ? (f3_q[1] ? r_fix : q_fix)
                            : ((f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[PW-1:XLEN]);
  // Fast-path results are parked in the accumulator low bits during PREP.
  assign final_res = fast_q ? acc[XLEN-1:0] : calc_res;

  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    case (state)
      IDLE: begin
        if (start_i && !flush_i) begin
          state_nxt = PREP;
          stall_o   = 1'b1;
        end
      end
      PREP: begin
        stall_o   = 1'b1;
        state_nxt = CALC;
      end
      CALC: begin
        stall_o = 1'b1;
        if (fast_q || (cnt == CW'(XLEN - 1))) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      f3_q      <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      rd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      fast_q    <= 1'b0;
      result_o  <= '0;
      rd_addr_o <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start_i && !flush_i) begin
            f3_q  <= funct3_i;
            op1_q <= op1_i;
            op2_q <= op2_i;
            rd_q  <= rd_addr_i;
          end
        end
        PREP: begin
          a_q    <= {{XLEN{1'b0}}, mag1};
          b_q    <= mag2;
          cnt    <= '0;
          neg_q  <= neg1 ^ neg2;
          rneg_q <= neg1;
          fast_q <= div_zero | div_ovf;
          acc    <= (div_zero | div_ovf) ? {{(XLEN+1){1'b0}}, fixed_res} : '0;
        end
        CALC: begin
          acc <= step_acc;
          cnt <= cnt + CW'(1);
          a_q <= a_q << 1;
          if (!is_div) b_q <= b_q >> 1;
          if (state_nxt == DONE) begin
            result_o  <= final_res;
            rd_addr_o <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);
  assign dbg_state_o = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN=32 and XLEN=8: results, latency, stall,
// flush and reset behaviour against hand-computed values.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start32, start8, flush;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] op1_32, op2_32;
  logic [7:0]  op1_8, op2_8;

  logic        stall32, busy32, done32, stall8, busy8, done8;
  logic [31:0] res32;
  logic [7:0]  res8;
  logic [4:0]  rd32, rd8;
  logic [1:0]  dbg32, dbg8;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  muldiv_unit #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .start_i(start32), .funct3_i(funct3), .op1_i(op1_32),
    .op2_i(op2_32), .rd_addr_i(rd), .flush_i(flush), .stall_o(stall32), .busy_o(busy32),
    .done_o(done32), .result_o(res32), .rd_addr_o(rd32), .dbg_state_o(dbg32)
  );

  muldiv_unit #(.XLEN(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .funct3_i(funct3), .op1_i(op1_8),
    .op2_i(op2_8), .rd_addr_i(rd), .flush_i(flush), .stall_o(stall8), .busy_o(busy8),
    .done_o(done8), .result_o(res8), .rd_addr_o(rd8), .dbg_state_o(dbg8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one request for a cycle; returns just after the accept edge.
  task automatic issue(input bit w8, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp);
    funct3 = f;
    rd     = r;
    if (w8) begin
      op1_8 = a[7:0]; op2_8 = b[7:0]; start8 = 1'b1;
    end else begin
      op1_32 = a; op2_32 = b; start32 = 1'b1;
    end
    exp_q.push_back(exp);
    #1;
    chk("stall_on_start", 64'(w8 ? stall8 : stall32), 64'(1));
    step();
    start8  = 1'b0;
    start32 = 1'b0;
  endtask

  task automatic collect(input bit w8, input int exp_lat, input logic [4:0] exp_rd,
                         input string tag);
    int          lat;
    bit          stall_ok;
    logic [31:0] exp, res;
    lat      = 0;
    stall_ok = 1'b1;
    while (((w8 ? done8 : done32) !== 1'b1) && lat < 100) begin
      if ((w8 ? stall8 : stall32) !== 1'b1) stall_ok = 1'b0;
      step();
      lat++;
    end
    exp = exp_q.pop_front();
    res = w8 ? {24'h0, res8} : res32;
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_result"}, 64'(res), 64'(exp));
    chk({tag, "_stall_hold"}, 64'(stall_ok), 64'(1));
    chk({tag, "_stall_done"}, 64'(w8 ? stall8 : stall32), 64'(0));
    chk({tag, "_rd"}, 64'(w8 ? rd8 : rd32), 64'(exp_rd));
    step();
    chk({tag, "_done_pulse"}, 64'(w8 ? done8 : done32), 64'(0));
  endtask

  initial begin
    bit saw_done;
    start32 = 1'b0; start8 = 1'b0; flush = 1'b0; funct3 = 3'd0; rd = 5'd0;
    op1_32 = '0; op2_32 = '0; op1_8 = '0; op2_8 = '0;
    #2;
    chk("rst_result", 64'(res32), 64'(0));
    chk("rst_rd", 64'(rd32), 64'(0));
    chk("rst_done", 64'(done32), 64'(0));
    chk("rst_busy", 64'(busy32), 64'(0));
    chk("rst_stall", 64'(stall32), 64'(0));
    step(); step();
    rst = 1'b0;
    step();

    // XLEN=32 multiplies
    issue(0, 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB);
    collect(0, 33, 5'd1, "mul_7xm3");
    issue(0, 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000);
    collect(0, 33, 5'd2, "mulh_min");
    issue(0, 3'b011, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'h4000_0000);
    collect(0, 33, 5'd3, "mulhu");
    issue(0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF);
    collect(0, 33, 5'd4, "mulhsu");

    // XLEN=32 divides
    issue(0, 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD);
    collect(0, 33, 5'd5, "div_m7_2");
    issue(0, 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF);
    collect(0, 33, 5'd6, "rem_m7_2");
    issue(0, 3'b101, 32'd100, 32'd7, 5'd7, 32'd14);
    collect(0, 33, 5'd7, "divu_100_7");
    issue(0, 3'b111, 32'd100, 32'd7, 5'd8, 32'd2);
    collect(0, 33, 5'd8, "remu_100_7");

    // Fast paths
    issue(0, 3'b101, 32'h1234_5678, 32'd0, 5'd9, 32'hFFFF_FFFF);
    collect(0, 2, 5'd9, "divu_by0");
    issue(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0);
    collect(0, 2, 5'd10, "rem_ovf");
    issue(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
    collect(0, 2, 5'd11, "div_ovf");
    issue(0, 3'b111, 32'hDEAD_BEEF, 32'd0, 5'd12, 32'hDEAD_BEEF);
    collect(0, 2, 5'd12, "remu_by0");

    // Flush at CALC step 10, then a new MUL in the next IDLE cycle
    funct3 = 3'b000; op1_32 = 32'd5; op2_32 = 32'd6; rd = 5'd13; start32 = 1'b1;
    step();
    start32  = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step();
      if (done32 === 1'b1) saw_done = 1'b1;
    end
    chk("flush_in_calc", 64'(dbg32), 64'(2));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", 64'(busy32), 64'(0));
    chk("flush_no_done", 64'(saw_done | done32), 64'(0));
    chk("flush_result_kept", 64'(res32), 64'(32'hDEAD_BEEF));
    chk("flush_rd_kept", 64'(rd32), 64'(12));
    issue(0, 3'b000, 32'd3, 32'd4, 5'd14, 32'd12);
    collect(0, 33, 5'd14, "mul_after_flush");

    // Reset in the middle of CALC
    funct3 = 3'b000; op1_32 = 32'd9; op2_32 = 32'd9; rd = 5'd15; start32 = 1'b1;
    step();
    start32 = 1'b0;
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1;
    #1;
    chk("midrst_result", 64'(res32), 64'(0));
    chk("midrst_rd", 64'(rd32), 64'(0));
    chk("midrst_busy", 64'(busy32), 64'(0));
    chk("midrst_done", 64'(done32), 64'(0));
    chk("midrst_stall", 64'(stall32), 64'(0));
    step();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done32 === 1'b1) saw_done = 1'b1;
    end
    chk("midrst_no_done", 64'(saw_done), 64'(0));

    // XLEN=8
    issue(1, 3'b000, 32'h0F, 32'h0F, 5'd20, 32'hE1);
    collect(1, 9, 5'd20, "x8_mul");
    issue(1, 3'b100, 32'h80, 32'hFF, 5'd21, 32'h80);
    collect(1, 2, 5'd21, "x8_div_ovf");
    issue(1, 3'b101, 32'hFF, 32'h10, 5'd22, 32'h0F);
    collect(1, 9, 5'd22, "x8_divu");
    issue(1, 3'b110, 32'h85, 32'h0A, 5'd23, 32'hFD);
    collect(1, 9, 5'd23, "x8_rem_neg");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
